softex_fp_minmax_acc: RTL and testbench

Streaming row accumulator that consumes the per-beat scalar output of the vector min/max reduction tree (value, strobe, valid/ready) and folds consecutive beats into one running minimum or maximum per row. After `len` accepted beats it presents a single result with a strobe and holds it under a valid/ready handshake. It sits directly downstream of the reduction stage in the softmax datapath and feeds the row maximum to the exponent/normalisation stages.

---
 rtl/softex_fp_minmax_acc_pkg.sv | 47 ++++
 rtl/softex_fp_minmax_rec.sv | 60 ++++++
 rtl/softex_fp_minmax_acc.sv | 128 ++++++++++++
 tb/tb_softex_fp_minmax_acc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/softex_fp_minmax_acc_pkg.sv
// Shared types and FP-format helpers for the softmax min/max row accumulator.
package softex_fp_minmax_acc_pkg;

   typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

   localparam fp_format_e FPFORMAT_IN = FP16ALT;
   localparam int unsigned MAX_WIDTH = 64;

   typedef enum logic {MIN = 1'b0, MAX = 1'b1} min_max_mode_t;

   typedef enum logic [1:0] {IDLE, ACC, OUT} minmax_acc_state_t;

   function automatic int unsigned exp_bits(fp_format_e f);
      case (f)
         FP32:    return 8;
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(fp_format_e f);
      case (f)
         FP32:    return 23;
         FP64:    return 52;
         FP16:    return 10;
         FP8:     return 2;
         default: return 7;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e f);
      return 1 + exp_bits(f) + man_bits(f);
   endfunction

   // Quiet, positive NaN: exponent all ones plus the mantissa MSB.
   function automatic logic [MAX_WIDTH-1:0] canonical_nan(fp_format_e f);
      logic [MAX_WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i <= exp_bits(f); i++) begin
         r[man_bits(f) - 1 + i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/softex_fp_minmax_rec.sv
// Strobed N-operand minNum/maxNum reduction; result is canonicalised so an
// unstrobed or NaN outcome always leaves as the canonical quiet NaN.
module softex_fp_minmax_rec
   import softex_fp_minmax_acc_pkg::*;
#(
   parameter fp_format_e  FPFORMAT = FPFORMAT_IN,
   parameter int unsigned N_INP    = 2,
   localparam int unsigned WIDTH   = fp_width(FPFORMAT)
) (
   input  logic [N_INP-1:0][WIDTH-1:0] data_i,
   input  logic [N_INP-1:0]            strb_i,
   input  min_max_mode_t               mode_i,
   output logic [WIDTH-1:0]            res_o,
   output logic                        strb_o
);

   localparam int unsigned EXP = exp_bits(FPFORMAT);
   localparam int unsigned MAN = man_bits(FPFORMAT);
   localparam logic [MAX_WIDTH-1:0] CANON_FULL = canonical_nan(FPFORMAT);
   localparam logic [WIDTH-1:0] CANON = CANON_FULL[WIDTH-1:0];

   function automatic logic is_nan(logic [WIDTH-1:0] v);
      return (&v[WIDTH-2 -: EXP]) && (|v[MAN-1:0]);
   endfunction

   function automatic logic [WIDTH-1:0] fold2(logic [WIDTH-1:0] a, logic sa,
                                              logic [WIDTH-1:0] b, logic sb,
                                              min_max_mode_t mode);
      logic [WIDTH-1:0] r;
      logic             lt;
      // Sign-magnitude order; differing signs also give -0 < +0.
      if (a[WIDTH-1] != b[WIDTH-1]) lt = a[WIDTH-1];
      else if (a[WIDTH-1])          lt = a[WIDTH-2:0] > b[WIDTH-2:0];
      else                          lt = a[WIDTH-2:0] < b[WIDTH-2:0];
      if (!sb)                           r = a;
      else if (!sa)                      r = b;
      else if (is_nan(a) && is_nan(b))   r = CANON;
      else if (is_nan(a))                r = b;
      else if (is_nan(b))                r = a;
      else if (mode == MIN)              r = lt ? a : b;
      else                               r = lt ? b : a;
      return r;
   endfunction

   logic [WIDTH-1:0] acc;
   logic             accs;

   always_comb begin
      acc  = data_i[0];
      accs = strb_i[0];
      for (int unsigned i = 1; i < N_INP; i++) begin
         acc  = fold2(acc, accs, data_i[i], strb_i[i], mode_i);
         accs = accs | strb_i[i];
      end
   end

   assign res_o  = (!accs || is_nan(acc)) ? CANON : acc;
   assign strb_o = accs;

endmodule

// File: rtl/softex_fp_minmax_acc.sv
// Row accumulator: folds len strobed beats into one min/max result and holds
// it under a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a row
//   ACC   | accumulating beats 2..len
//   OUT   | presenting the row result
module softex_fp_minmax_acc
   import softex_fp_minmax_acc_pkg::*;
#(
   parameter fp_format_e  FPFORMAT  = FPFORMAT_IN,
   parameter int unsigned CNT_WIDTH = 16,
   localparam int unsigned WIDTH    = fp_width(FPFORMAT)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [WIDTH-1:0]     data_i,
   input  logic                 strb_i,
   input  min_max_mode_t        mode_i,
   input  logic [CNT_WIDTH-1:0] len_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [WIDTH-1:0]     res_o,
   output logic                 strb_o
);

   minmax_acc_state_t    state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, len_eff, cnt_inc;
   min_max_mode_t        mode_q, mode_d, fold_mode;
   logic [WIDTH-1:0]     acc_q, acc_d, res_q, res_d, fold_res;
   logic                 accstrb_q, accstrb_d, rstrb_q, rstrb_d, fold_strb;

   assign len_eff   = (len_i == '0) ? CNT_WIDTH'(1) : len_i;
   assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
   assign fold_mode = (state_q == IDLE) ? mode_i : mode_q;

   // In IDLE the stale accumulator is masked so the fold just passes the first beat.
   softex_fp_minmax_rec #(
      .FPFORMAT (FPFORMAT),
      .N_INP    (2)
   ) i_fold (
      .data_i ({data_i, acc_q}),
      .strb_i ({strb_i, accstrb_q & (state_q != IDLE)}),
      .mode_i (fold_mode),
      .res_o  (fold_res),
      .strb_o (fold_strb)
   );

   assign ready_o = enable_i & (state_q != OUT);
   assign valid_o = (state_q == OUT);
   assign res_o   = res_q;
   assign strb_o  = rstrb_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      mode_d    = mode_q;
      acc_d     = acc_q;
      accstrb_d = accstrb_q;
      res_d     = res_q;
      rstrb_d   = rstrb_q;
      if (clear_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         acc_d     = '0;
         accstrb_d = 1'b0;
         res_d     = '0;
         rstrb_d   = 1'b0;
      end else if (enable_i) begin
         case (state_q)
            IDLE: if (valid_i) begin
               mode_d    = mode_i;
               len_d     = len_eff;
               acc_d     = fold_res;
               accstrb_d = fold_strb;
               cnt_d     = CNT_WIDTH'(1);
               if (len_eff == CNT_WIDTH'(1)) begin
                  state_d = OUT;
                  res_d   = fold_res;
                  rstrb_d = fold_strb;
               end else begin
                  state_d = ACC;
               end
            end
            ACC: if (valid_i) begin
               acc_d     = fold_res;
               accstrb_d = fold_strb;
               cnt_d     = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = OUT;
                  res_d   = fold_res;
                  rstrb_d = fold_strb;
               end
            end
            OUT: if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= CNT_WIDTH'(1);
         mode_q    <= MIN;
         acc_q     <= '0;
         accstrb_q <= 1'b0;
         res_q     <= '0;
         rstrb_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         acc_q     <= acc_d;
         accstrb_q <= accstrb_d;
         res_q     <= res_d;
         rstrb_q   <= rstrb_d;
      end
   end

endmodule

// File: tb/tb_softex_fp_minmax_acc.sv
// Scoreboard bench for the BF16 min/max row accumulator using directed rows.
module tb_softex_fp_minmax_acc;
   import softex_fp_minmax_acc_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clear_i, enable_i, valid_i, ready_o, strb_i;
   logic          valid_o, ready_i, strb_o;
   logic [15:0]   data_i, len_i, res_o;
   min_max_mode_t mode_i;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] res;
      logic        strb;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   softex_fp_minmax_acc #(
      .FPFORMAT  (FP16ALT),
      .CNT_WIDTH (16)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .enable_i (enable_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .strb_i   (strb_i),
      .mode_i   (mode_i),
      .len_i    (len_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .res_o    (res_o),
      .strb_o   (strb_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a handshake happens at the coming posedge whenever these hold.
   always @(negedge clk_i) begin
      if (rst_ni && enable_i && !clear_i && valid_o && ready_i) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got %h expected none", res_o);
         end else begin
            mon_e = sb_q.pop_front();
            chk("row_res", 32'(res_o), 32'(mon_e.res));
            chk("row_strb", 32'(strb_o), 32'(mon_e.strb));
         end
      end
   end

   task automatic push_exp(input logic [15:0] r, input logic s);
      exp_t e;
      e.res  = r;
      e.strb = s;
      sb_q.push_back(e);
   endtask

   task automatic drive_beat(input logic [15:0] d, input logic s, input min_max_mode_t m,
                             input logic [15:0] l);
      int tries = 0;
      valid_i = 1'b1;
      data_i  = d;
      strb_i  = s;
      mode_i  = m;
      len_i   = l;
      @(negedge clk_i);
      while (!ready_o && tries < 50) begin
         tries++;
         @(negedge clk_i);
      end
      if (!ready_o) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: got ready_o=0 expected 1 within 50 cycles");
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic row(input min_max_mode_t m, input logic [15:0] l, input int n,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3,
                      input logic [3:0] s, input logic [15:0] er, input logic es);
      logic [15:0] d [4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      push_exp(er, es);
      for (int i = 0; i < n; i++) drive_beat(d[i], s[i], m, l);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; valid_i = 1'b0;
      data_i = '0; strb_i = 1'b0; mode_i = MIN; len_i = '0; ready_i = 1'b1;
      @(negedge clk_i);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_res", 32'(res_o), 0);
      chk("rst_strb", 32'(strb_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      idle(1);

      // MAX row, then next row's first beat held during the OUT cycle
      row(MAX, 4, 4, 16'h3F80, 16'hC040, 16'h4000, 16'h3F80, 4'b1111, 16'h4000, 1'b1);
      push_exp(16'hC040, 1'b1);
      valid_i = 1'b1; data_i = 16'h3F80; strb_i = 1'b1; mode_i = MIN; len_i = 4;
      @(negedge clk_i);
      chk("lat_valid", 32'(valid_o), 1);
      chk("out_ready", 32'(ready_o), 0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("idle_valid", 32'(valid_o), 0);
      chk("idle_ready", 32'(ready_o), 1);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      // mode and len changes mid-row must be ignored
      drive_beat(16'hC040, 1'b1, MAX, 3);
      drive_beat(16'h4000, 1'b1, MAX, 3);
      drive_beat(16'h3F80, 1'b1, MAX, 3);
      idle(2);

      row(MAX, 3, 3, 16'h7FC0, 16'h4000, 16'h3F80, 16'h0, 4'b0101, 16'h3F80, 1'b1);
      idle(2);
      row(MAX, 2, 2, 16'h4000, 16'h3F80, 16'h0, 16'h0, 4'b0000, 16'h7FC0, 1'b0);
      idle(2);
      row(MAX, 0, 1, 16'h4000, 16'h0, 16'h0, 16'h0, 4'b0001, 16'h4000, 1'b1);
      idle(2);
      row(MIN, 1, 1, 16'hFF81, 16'h0, 16'h0, 16'h0, 4'b0001, 16'h7FC0, 1'b1);
      idle(2);
      row(MAX, 2, 2, 16'h7FC1, 16'hFFC0, 16'h0, 16'h0, 4'b0011, 16'h7FC0, 1'b1);
      idle(2);
      row(MIN, 2, 2, 16'h8000, 16'h0000, 16'h0, 16'h0, 4'b0011, 16'h8000, 1'b1);
      idle(2);
      row(MAX, 2, 2, 16'h0000, 16'h8000, 16'h0, 16'h0, 4'b0011, 16'h0000, 1'b1);
      idle(2);
      row(MIN, 3, 3, 16'h4000, 16'hC040, 16'h3F80, 16'h0, 4'b0110, 16'hC040, 1'b1);
      idle(2);

      // Backpressure with the next row's beat waiting
      ready_i = 1'b0;
      row(MAX, 2, 2, 16'h3F80, 16'h4000, 16'h0, 16'h0, 4'b0011, 16'h4000, 1'b1);
      push_exp(16'h3F80, 1'b1);
      valid_i = 1'b1; data_i = 16'h3F80; strb_i = 1'b1; mode_i = MAX; len_i = 1;
      repeat (5) begin
         @(negedge clk_i);
         chk("bp_valid", 32'(valid_o), 1);
         chk("bp_res", 32'(res_o), 32'h4000);
         chk("bp_strb", 32'(strb_o), 1);
         chk("bp_ready", 32'(ready_o), 0);
         @(posedge clk_i); #1;
      end
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("bp_idle_ready", 32'(ready_o), 1);
      chk("bp_idle_valid", 32'(valid_o), 0);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      idle(2);

      // Stall mid-row with a tempting beat presented
      push_exp(16'h4000, 1'b1);
      drive_beat(16'h3F80, 1'b1, MAX, 3);
      enable_i = 1'b0;
      valid_i = 1'b1; data_i = 16'h4100; strb_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk("stall_ready", 32'(ready_o), 0);
         chk("stall_valid", 32'(valid_o), 0);
         @(posedge clk_i); #1;
      end
      enable_i = 1'b1;
      drive_beat(16'hC040, 1'b1, MAX, 3);
      drive_beat(16'h4000, 1'b1, MAX, 3);
      idle(2);

      // Clear discards a partial row
      drive_beat(16'h4100, 1'b1, MAX, 4);
      drive_beat(16'h4100, 1'b1, MAX, 4);
      clear_i = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0;
      @(negedge clk_i);
      chk("clr_valid", 32'(valid_o), 0);
      chk("clr_ready", 32'(ready_o), 1);
      @(posedge clk_i); #1;
      row(MAX, 4, 4, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 4'b1111, 16'h4000, 1'b1);
      idle(2);

      // Asynchronous reset while presenting a result
      ready_i = 1'b0;
      drive_beat(16'h4000, 1'b1, MAX, 1);
      @(negedge clk_i);
      chk("pre_rst_valid", 32'(valid_o), 1);
      rst_ni = 1'b0;
      #1;
      chk("async_rst_valid", 32'(valid_o), 0);
      chk("async_rst_res", 32'(res_o), 0);
      chk("async_rst_strb", 32'(strb_o), 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      ready_i = 1'b1;
      row(MIN, 2, 2, 16'h3F80, 16'hC040, 16'h0, 16'h0, 4'b0011, 16'hC040, 1'b1);
      idle(4);

      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
